// File: rtl/bcm_seq_pkg.sv
// bcm_seq_pkg: state encodings and width helpers shared by the BCM scan sequencer.
package bcm_seq_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_SHIFT, S_WAIT_SHIFT, S_LATCH, S_ARM, S_DISPLAY,
        S_CLOSE, S_WAIT_FINISH, S_ROW_NEXT, S_DONE, S_DEAD
    } state_t;

    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/seq_counter.sv
// seq_counter: index counter with synchronous clear, saturating increment and terminal flag.
module seq_counter #(
    parameter int W   = 2,
    parameter int MAX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_q,
    output logic         o_tc
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk)
        if (rst || i_clr) r_q <= '0;
        else if (i_inc && !o_tc) r_q <= r_q + 1'b1;

    assign o_q  = r_q;
    assign o_tc = r_q == W'(MAX);
endmodule

// File: rtl/bcm_scan_sequencer.sv
// bcm_scan_sequencer: frame/row/bit-plane scheduler driving the row shifter and BCM timer.
// Define BCM_SEQ_DEADTIME_EN to insert DEADTIME blank cycles after each row change.
module bcm_scan_sequencer
    import bcm_seq_pkg::*;
#(
    parameter int NUM_ROWS   = 32,
    parameter int NUM_PLANES = 4,
    parameter int ROW_W      = clog2_min1(NUM_ROWS),
    parameter int PLANE_W    = clog2_min1(NUM_PLANES)
`ifdef BCM_SEQ_DEADTIME_EN
    ,
    parameter int DEADTIME   = 4
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_START,
    output logic               out_BUSY,
    output logic               out_FRAME_DONE,
    output logic               out_SHIFT_START,
    input  logic               in_SHIFT_DONE,
    output logic               out_LATCH,
    output logic               out_BLANK,
    output logic [ROW_W-1:0]   out_ROW,
    output logic [PLANE_W-1:0] out_PLANE,
    output logic               out_BCM_RST,
    output logic               out_BCM_INIT,
    output logic               out_BCM_CONTINUE,
    input  logic               in_BCM_NEXT_PLANE,
    input  logic               in_BCM_FINISH
);
    state_t r_state, w_next;
    logic   w_row_tc, w_plane_tc, w_dead_done;
    logic   w_start;

    assign w_start = r_state == S_IDLE && in_START;

    seq_counter #(.W(ROW_W), .MAX(NUM_ROWS - 1)) u_row (
        .clk(clk), .rst(rst),
        .i_clr(w_start || r_state == S_DONE),
        .i_inc(r_state == S_ROW_NEXT),
        .o_q(out_ROW), .o_tc(w_row_tc)
    );

    seq_counter #(.W(PLANE_W), .MAX(NUM_PLANES - 1)) u_plane (
        .clk(clk), .rst(rst),
        .i_clr(w_start || r_state == S_ROW_NEXT),
        .i_inc(r_state == S_DISPLAY && in_BCM_NEXT_PLANE),
        .o_q(out_PLANE), .o_tc(w_plane_tc)
    );

`ifdef BCM_SEQ_DEADTIME_EN
    localparam int DEAD_W = clog2_min1(DEADTIME + 1);
    logic [DEAD_W-1:0] r_dead;

    // Loaded on the row change so DEAD lasts DEADTIME cycles (at least one).
    always_ff @(posedge clk)
        if (rst) r_dead <= '0;
        else if (r_state == S_ROW_NEXT) r_dead <= DEAD_W'(DEADTIME);
        else if (r_state == S_DEAD && r_dead != '0) r_dead <= r_dead - 1'b1;

    assign w_dead_done = r_dead <= DEAD_W'(1);
`else
    assign w_dead_done = 1'b1;
`endif

    always_ff @(posedge clk)
        if (rst) r_state <= S_IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:        w_next = in_START ? S_SHIFT : S_IDLE;
            S_SHIFT:       w_next = S_WAIT_SHIFT;
            S_WAIT_SHIFT:  w_next = in_SHIFT_DONE ? S_LATCH : S_WAIT_SHIFT;
            S_LATCH:       w_next = S_ARM;
            S_ARM:         w_next = S_DISPLAY;
            S_DISPLAY:     w_next = !in_BCM_NEXT_PLANE ? S_DISPLAY : w_plane_tc ? S_CLOSE : S_SHIFT;
            S_CLOSE:       w_next = S_WAIT_FINISH;
            S_WAIT_FINISH: w_next = in_BCM_FINISH ? S_ROW_NEXT : S_WAIT_FINISH;
`ifdef BCM_SEQ_DEADTIME_EN
            S_ROW_NEXT:    w_next = w_row_tc ? S_DONE : S_DEAD;
            S_DEAD:        w_next = w_dead_done ? S_SHIFT : S_DEAD;
`else
            S_ROW_NEXT:    w_next = w_row_tc ? S_DONE : (w_dead_done ? S_SHIFT : S_IDLE);
`endif
            S_DONE:        w_next = S_IDLE;
            default:       w_next = S_IDLE;
        endcase
    end

    always_comb begin
        out_BUSY         = r_state != S_IDLE;
        out_FRAME_DONE   = r_state == S_DONE;
        out_SHIFT_START  = r_state == S_SHIFT;
        out_LATCH        = r_state == S_LATCH;
        out_BLANK        = !(r_state == S_ARM || r_state == S_DISPLAY);
        out_BCM_RST      = r_state == S_IDLE || r_state == S_ROW_NEXT;
        out_BCM_INIT     = r_state == S_ARM && out_PLANE == '0;
        out_BCM_CONTINUE = (r_state == S_ARM && out_PLANE != '0) || r_state == S_CLOSE;
    end
endmodule
